// File: rtl/uart_pkg.sv
// Shared UART definitions: default character width, ASCII codes, status-register layout.
package uart_pkg;

  localparam int UART_DWIDTH = 8;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  // Bit positions inside the memory-mapped TX status register.
  localparam int STAT_EMPTY_BIT    = 0;
  localparam int STAT_FULL_BIT     = 1;
  localparam int STAT_OVERFLOW_BIT = 2;
  localparam int STAT_COUNT_LSB    = 8;

  // Release state of the TX FIFO output; derived every cycle, never stored.
  typedef enum logic {
    REL_HOLD    = 1'b0,
    REL_RELEASE = 1'b1
  } rel_state_e;

  // Assemble a 32-bit status word from the FIFO flags and an occupancy count.
  function automatic logic [31:0] pack_status(input logic       empty,
                                              input logic       full,
                                              input logic       overflow,
                                              input logic [7:0] cnt);
    logic [31:0] s;
    s                                       = '0;
    s[STAT_EMPTY_BIT]                       = empty;
    s[STAT_FULL_BIT]                        = full;
    s[STAT_OVERFLOW_BIT]                    = overflow;
    s[STAT_COUNT_LSB +: 8]                  = cnt;
    return s;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the TX FIFO: synchronous write, asynchronous read.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DWIDTH = UART_DWIDTH,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DWIDTH-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DWIDTH-1:0]        rdata
);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  // Write port: contents carry no reset, only pointers define validity.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port is combinational so the head entry falls through immediately.
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Character FIFO between the core store path and the UART transmitter,
// with optional line-buffered release and sticky overflow status.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int                DWIDTH  = UART_DWIDTH,
  parameter int                DEPTH   = 16,
  parameter logic [DWIDTH-1:0] LF_CODE = DWIDTH'(ASCII_LF)
) (
  input  logic                     uart_clk,
  input  logic                     uart_rst,
  input  logic [DWIDTH-1:0]        wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     flush,
  input  logic                     line_mode,
  output logic [DWIDTH-1:0]        core_txdata,
  output logic                     core_txvalid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] nl_pending_q, nl_pending_d;
  logic             overflow_q, overflow_d;

  logic             push;
  logic             pop;
  logic             push_lf;
  logic             pop_lf;
  logic             mem_we;
  rel_state_e       rel_state;

  uart_fifo_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (uart_clk),
    .we    (mem_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (core_txdata)
  );

  // Occupancy flags from the pointers; the extra MSB separates full from empty.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    count    = wr_ptr_q - rd_ptr_q;
    overflow = overflow_q;
    wr_ready = !full;
  end

  // Release decision: hold partial lines in line mode, but a full FIFO always drains.
  always_comb begin
    rel_state = REL_RELEASE;
    if (line_mode && (nl_pending_q == '0) && !full) begin
      rel_state = REL_HOLD;
    end
    core_txvalid = !empty && (rel_state == REL_RELEASE);
  end

  // Handshake qualification; flush suppresses any same-cycle transfer.
  always_comb begin
    push    = wr_valid && !full;
    pop     = core_txvalid && tx_ready;
    push_lf = push && (wr_data == LF_CODE);
    pop_lf  = pop && (core_txdata == LF_CODE);
    mem_we  = push && !flush;
  end

  // Next-state for pointers, pending-line counter and sticky overflow.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    nl_pending_d = nl_pending_q;
    overflow_d   = overflow_q;
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      nl_pending_d = '0;
      overflow_d   = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (wr_valid && full) begin
        overflow_d = 1'b1;
      end
      case ({push_lf, pop_lf})
        2'b10:   nl_pending_d = nl_pending_q + PTR_W'(1);
        2'b01:   nl_pending_d = nl_pending_q - PTR_W'(1);
        default: nl_pending_d = nl_pending_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge uart_clk) begin
    if (uart_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      nl_pending_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      nl_pending_q <= nl_pending_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected characters,
// a negedge monitor pops and compares every accepted output character.
module tb_uart_tx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          uart_clk;
  logic          uart_rst;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          flush;
  logic          line_mode;
  logic [DW-1:0] core_txdata;
  logic          core_txvalid;
  logic          tx_ready;
  logic [4:0]    count;
  logic          full;
  logic          empty;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q [$];

  logic          prev_hold_vld = 1'b0;
  logic [DW-1:0] prev_data     = '0;
  logic          prev_disrupt  = 1'b0;
  logic [DW-1:0] mon_exp;

  uart_tx_fifo #(
    .DWIDTH  (DW),
    .DEPTH   (DEPTH),
    .LF_CODE (8'h0A)
  ) dut (
    .uart_clk     (uart_clk),
    .uart_rst     (uart_rst),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .flush        (flush),
    .line_mode    (line_mode),
    .core_txdata  (core_txdata),
    .core_txvalid (core_txvalid),
    .tx_ready     (tx_ready),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow)
  );

  initial uart_clk = 1'b0;
  always #5 uart_clk = ~uart_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge uart_clk);
    #1;
  endtask

  // Push DEPTH bytes from base with the transmitter stalled, then one more that must be dropped.
  task automatic fill_overflow(input logic [DW-1:0] base);
    tx_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + DW'(i);
      if (i < DEPTH) exp_q.push_back(base + DW'(i));
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (empty !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check(name, {31'b0, empty}, 32'd1);
    check({name, "_queue"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_ready"}, {31'b0, wr_ready}, 32'd1);
    check({tag, "_txvalid"},  {31'b0, core_txvalid}, 32'd0);
    check({tag, "_count"},    {27'b0, count}, 32'd0);
    check({tag, "_empty"},    {31'b0, empty}, 32'd1);
    check({tag, "_full"},     {31'b0, full}, 32'd0);
    check({tag, "_overflow"}, {31'b0, overflow}, 32'd0);
  endtask

  // Output monitor: every accepted character must match the scoreboard head,
  // and a stalled offer must not change before it is taken.
  always @(negedge uart_clk) begin
    if (prev_hold_vld && !prev_disrupt) begin
      checks++;
      if (core_txvalid !== 1'b1 || core_txdata !== prev_data) begin
        failures++;
        $display("FAIL hold_stable: got valid=%0b data=0x%0h, want valid=1 data=0x%0h",
                 core_txvalid, core_txdata, prev_data);
      end
    end
    if (core_txvalid === 1'b1 && tx_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got 0x%0h, want no output", core_txdata);
      end else begin
        mon_exp = exp_q.pop_front();
        check("txdata", {24'b0, core_txdata}, {24'b0, mon_exp});
      end
    end
    prev_hold_vld = (core_txvalid === 1'b1) && (tx_ready === 1'b0);
    prev_data     = core_txdata;
    prev_disrupt  = (flush === 1'b1) || (uart_rst === 1'b1);
  end

  initial begin
    int m_count;
    logic pop_exp;

    uart_rst  = 1'b1;
    wr_data   = '0;
    wr_valid  = 1'b0;
    flush     = 1'b0;
    line_mode = 1'b0;
    tx_ready  = 1'b0;
    tick();
    tick();
    uart_rst = 1'b0;
    check_reset_outputs("reset");

    // Basic flow
    tx_ready = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h48;
    exp_q.push_back(8'h48);
    tick();
    check("basic_count1", {27'b0, count}, 32'd1);
    check("basic_head1", {24'b0, core_txdata}, 32'h48);
    wr_data = 8'h69;
    exp_q.push_back(8'h69);
    tick();
    wr_valid = 1'b0;
    check("basic_count2", {27'b0, count}, 32'd1);
    check("basic_head2", {24'b0, core_txdata}, 32'h69);
    tick();
    check("basic_empty", {31'b0, empty}, 32'd1);
    check("basic_queue", exp_q.size(), 32'd0);

    // Fill and overflow
    fill_overflow(8'h00);
    check("fill_full", {31'b0, full}, 32'd1);
    check("fill_count", {27'b0, count}, 32'd16);
    check("fill_wr_ready", {31'b0, wr_ready}, 32'd0);
    check("fill_overflow", {31'b0, overflow}, 32'd1);
    tick();
    tick();
    tx_ready = 1'b1;
    wait_empty("fill_drain");
    check("overflow_sticky", {31'b0, overflow}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("overflow_cleared", {31'b0, overflow}, 32'd0);

    // Line mode
    line_mode = 1'b1;
    tx_ready  = 1'b1;
    wr_valid  = 1'b1;
    wr_data   = 8'h61;
    exp_q.push_back(8'h61);
    tick();
    check("lm_hold_a", {31'b0, core_txvalid}, 32'd0);
    wr_data = 8'h62;
    exp_q.push_back(8'h62);
    tick();
    check("lm_hold_b", {31'b0, core_txvalid}, 32'd0);
    wr_data = 8'h0A;
    exp_q.push_back(8'h0A);
    tick();
    wr_valid = 1'b0;
    check("lm_release", {31'b0, core_txvalid}, 32'd1);
    wait_empty("lm_drain");
    wr_valid = 1'b1;
    wr_data  = 8'h63;
    exp_q.push_back(8'h63);
    tick();
    wr_valid = 1'b0;
    check("lm_nl_cleared", {31'b0, core_txvalid}, 32'd0);
    tick();
    check("lm_still_held", {27'b0, count}, 32'd1);
    line_mode = 1'b0;
    wait_empty("lm_mode_off_drain");

    // Wrap and simultaneous push/pop with a stall pattern
    m_count = 0;
    for (int i = 0; i < 40; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h80 + DW'(i);
      tx_ready = (i % 3) != 0;
      exp_q.push_back(8'h80 + DW'(i));
      pop_exp = (m_count > 0) && tx_ready;
      tick();
      m_count = m_count + 1 - int'(pop_exp);
      check("wrap_count", {27'b0, count}, m_count);
    end
    wr_valid = 1'b0;
    tx_ready = 1'b1;
    wait_empty("wrap_drain");

    // Flush mid-stream
    fill_overflow(8'h20);
    tx_ready = 1'b1;
    repeat (11) tick();
    tx_ready = 1'b0;
    check("flush_pre_count", {27'b0, count}, 32'd5);
    check("flush_pre_overflow", {31'b0, overflow}, 32'd1);
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    tick();
    flush    = 1'b0;
    wr_valid = 1'b0;
    exp_q.delete();
    check("flush_count", {27'b0, count}, 32'd0);
    check("flush_overflow", {31'b0, overflow}, 32'd0);
    check("flush_empty", {31'b0, empty}, 32'd1);
    check("flush_txvalid", {31'b0, core_txvalid}, 32'd0);
    tx_ready = 1'b1;
    repeat (3) tick();

    // Reset mid-stream
    fill_overflow(8'h40);
    tx_ready = 1'b1;
    repeat (11) tick();
    tx_ready = 1'b0;
    check("rst_pre_count", {27'b0, count}, 32'd5);
    check("rst_pre_overflow", {31'b0, overflow}, 32'd1);
    uart_rst = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    tick();
    uart_rst = 1'b0;
    wr_valid = 1'b0;
    exp_q.delete();
    check_reset_outputs("midrst");
    tx_ready = 1'b1;
    repeat (3) tick();
    check("midrst_empty_after", {31'b0, empty}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
